rvvi_frame_reducer: RTL and testbench

- Testbench-side RVVI frame reflector. Receives full RVVI trace frames on an AXI-Stream slave (Ethernet MAC RX side) and buffers up to DEPTH captured frames.
- Re-emits each frame as a reduced 7-word frame on an AXI-Stream master (MAC TX side). The reduced frame carries the instruction-count fields and a 32-bit host-load word.
- Successor to the fixed single-frame capture/echo logic:
  - proper rx_tready backpressure;
  - multi-frame buffering;
  - parametrised capture length;
  - short/overlong frame handling;
  - status counters.

---
 rtl/rvvi_frame_reducer.sv | 223 ++++++++++++++++++++++
 tb/tb_rvvi_frame_reducer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_frame_reducer.sv
// RVVI frame reflector: captures full RVVI trace frames from AXIS RX and re-emits reduced 7-word
// frames on AXIS TX. Optional frame dropping is enabled with `define RVVI_FRAME_DROP_EN.
module rvvi_frame_reducer #(
   parameter int unsigned IN_WORDS    = 12,
   parameter int unsigned DEPTH       = 2,
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned DROP_PERIOD = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [31:0]          rx_tdata,
   input  logic [3:0]           rx_tkeep,
   input  logic                 rx_tvalid,
   output logic                 rx_tready,
   input  logic                 rx_tlast,
   output logic [31:0]          tx_tdata,
   output logic [3:0]           tx_tkeep,
   output logic                 tx_tvalid,
   input  logic                 tx_tready,
   output logic                 tx_tlast,
   input  logic [31:0]          HostLoad,
   output logic [CNT_WIDTH-1:0] FramesRx,
   output logic [CNT_WIDTH-1:0] FramesTx,
   output logic [CNT_WIDTH-1:0] FramesBad,
   output logic [CNT_WIDTH-1:0] FramesDropped
);

   localparam int unsigned IW = $clog2(IN_WORDS);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OW = $clog2(DEPTH + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(IN_WORDS - 1);
   localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);
   localparam logic [OW:0]   DEPTH_C  = (OW + 1)'(DEPTH);

   typedef enum logic [1:0] {RIdle, RCapture, RSkip} rx_state_e;
   typedef enum logic {TIdle, TSend} tx_state_e;

   rx_state_e            rx_state_q;
   tx_state_e            tx_state_q;
   logic [31:0]          mem [DEPTH][IN_WORDS];
   logic [IW-1:0]        idx_q;
   logic [PW-1:0]        wslot_q, wr_ptr_q, rd_ptr_q, wr_sel, wr_slot;
   logic [IW-1:0]        wr_idx;
   logic [OW-1:0]        occ_q;
   logic [OW:0]          occ_eff;
   logic                 commit_q, do_commit, drop_hit, full, rx_hs, tx_done;
   logic [2:0]           k_q, k_sel;
   logic [31:0]          host_q, tx_data_q, nxt_word;
   logic                 tx_valid_q, tx_last_q;
   logic [CNT_WIDTH-1:0] frames_rx_q, frames_tx_q, frames_bad_q;
   logic                 unused_keep;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_MAX) ? '0 : p + PW'(1);
   endfunction

   assign unused_keep = ^rx_tkeep;

   assign do_commit = commit_q & ~drop_hit;
   assign tx_done   = tx_valid_q & tx_tready & tx_last_q;
   // A commit still in flight already owns a slot, so count it when judging fullness.
   assign occ_eff   = {1'b0, occ_q} + (OW + 1)'(do_commit);
   assign full      = (occ_eff == DEPTH_C);
   assign rx_tready = !((rx_state_q == RIdle) && full);
   assign rx_hs     = rx_tvalid & rx_tready;
   assign wr_sel    = do_commit ? ptr_inc(wr_ptr_q) : wr_ptr_q;
   assign wr_slot   = (rx_state_q == RIdle) ? wr_sel : wslot_q;
   assign wr_idx    = (rx_state_q == RIdle) ? '0 : idx_q;

   always_ff @(posedge clk) begin
      if (rx_hs && (rx_state_q != RSkip)) begin
         mem[wr_slot][wr_idx] <= rx_tdata;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_state_q   <= RIdle;
         idx_q        <= '0;
         wslot_q      <= '0;
         commit_q     <= 1'b0;
         frames_bad_q <= '0;
      end else begin
         commit_q <= 1'b0;
         if (rx_hs) begin
            case (rx_state_q)
               RIdle: begin
                  wslot_q <= wr_sel;
                  idx_q   <= IW'(1);
                  if (rx_tlast) frames_bad_q <= frames_bad_q + CNT_WIDTH'(1);
                  else          rx_state_q   <= RCapture;
               end
               RCapture: begin
                  if (rx_tlast) begin
                     rx_state_q <= RIdle;
                     if (idx_q == LAST_IDX) commit_q     <= 1'b1;
                     else                   frames_bad_q <= frames_bad_q + CNT_WIDTH'(1);
                  end else if (idx_q == LAST_IDX) begin
                     rx_state_q <= RSkip;
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end
               RSkip: begin
                  if (rx_tlast) begin
                     rx_state_q <= RIdle;
                     commit_q   <= 1'b1;
                  end
               end
               default: rx_state_q <= RIdle;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q    <= '0;
         occ_q       <= '0;
         frames_rx_q <= '0;
      end else begin
         if (do_commit) begin
            wr_ptr_q    <= ptr_inc(wr_ptr_q);
            frames_rx_q <= frames_rx_q + CNT_WIDTH'(1);
         end
         case ({do_commit, tx_done})
            2'b10:   occ_q <= occ_q + OW'(1);
            2'b01:   occ_q <= occ_q - OW'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   always_comb begin
      nxt_word = '0;
      k_sel    = (tx_state_q == TIdle) ? 3'd0 : k_q + 3'd1;
      case (k_sel)
         3'd0:    nxt_word = mem[rd_ptr_q][0];
         3'd1:    nxt_word = mem[rd_ptr_q][1];
         3'd2:    nxt_word = mem[rd_ptr_q][2];
         3'd3:    nxt_word = {mem[rd_ptr_q][8][31:16], mem[rd_ptr_q][3][15:0]};
         3'd4:    nxt_word = mem[rd_ptr_q][9];
         3'd5:    nxt_word = {host_q[15:0], mem[rd_ptr_q][10][15:0]};
         3'd6:    nxt_word = {16'h0, host_q[31:16]};
         default: nxt_word = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_state_q  <= TIdle;
         k_q         <= '0;
         host_q      <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         tx_last_q   <= 1'b0;
         rd_ptr_q    <= '0;
         frames_tx_q <= '0;
      end else begin
         case (tx_state_q)
            TIdle: begin
               if (occ_q != '0) begin
                  tx_state_q <= TSend;
                  k_q        <= 3'd0;
                  host_q     <= HostLoad;
                  tx_data_q  <= nxt_word;
                  tx_valid_q <= 1'b1;
                  tx_last_q  <= 1'b0;
               end
            end
            TSend: begin
               if (tx_tready) begin
                  if (k_q == 3'd6) begin
                     tx_state_q  <= TIdle;
                     tx_valid_q  <= 1'b0;
                     tx_last_q   <= 1'b0;
                     rd_ptr_q    <= ptr_inc(rd_ptr_q);
                     frames_tx_q <= frames_tx_q + CNT_WIDTH'(1);
                  end else begin
                     k_q       <= k_sel;
                     tx_data_q <= nxt_word;
                     tx_last_q <= (k_sel == 3'd6);
                  end
               end
            end
            default: tx_state_q <= TIdle;
         endcase
      end
   end

`ifdef RVVI_FRAME_DROP_EN
   localparam int unsigned DW = $clog2(DROP_PERIOD);
   logic [DW-1:0]        drop_cnt_q;
   logic [CNT_WIDTH-1:0] frames_drop_q;

   assign drop_hit = commit_q && (drop_cnt_q == DW'(DROP_PERIOD - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         drop_cnt_q    <= '0;
         frames_drop_q <= '0;
      end else if (commit_q) begin
         drop_cnt_q <= drop_hit ? '0 : drop_cnt_q + DW'(1);
         if (drop_hit) frames_drop_q <= frames_drop_q + CNT_WIDTH'(1);
      end
   end

   assign FramesDropped = frames_drop_q;
`else
   localparam int unsigned unused_drop_period = DROP_PERIOD;
   assign drop_hit      = 1'b0;
   assign FramesDropped = '0;
`endif

   assign tx_tdata  = tx_data_q;
   assign tx_tkeep  = 4'hF;
   assign tx_tvalid = tx_valid_q;
   assign tx_tlast  = tx_last_q;
   assign FramesRx  = frames_rx_q;
   assign FramesTx  = frames_tx_q;
   assign FramesBad = frames_bad_q;

endmodule

// File: tb/tb_rvvi_frame_reducer.sv
// Directed bench for rvvi_frame_reducer: reference beats come from hand tables and a small
// reduction model; checks drop behaviour too when RVVI_FRAME_DROP_EN is defined.
module tb_rvvi_frame_reducer;

   localparam int unsigned IN_WORDS    = 12;
   localparam int unsigned DEPTH       = 2;
   localparam int unsigned CNT_WIDTH   = 32;
   localparam int unsigned DROP_PERIOD = 8;
`ifdef RVVI_FRAME_DROP_EN
   localparam bit DropEn = 1'b1;
`else
   localparam bit DropEn = 1'b0;
`endif

   logic                 clk, resetn;
   logic [31:0]          rx_tdata, tx_tdata, HostLoad;
   logic [3:0]           rx_tkeep, tx_tkeep;
   logic                 rx_tvalid, rx_tready, rx_tlast;
   logic                 tx_tvalid, tx_tready, tx_tlast;
   logic [CNT_WIDTH-1:0] FramesRx, FramesTx, FramesBad, FramesDropped;

   rvvi_frame_reducer #(
      .IN_WORDS   (IN_WORDS),
      .DEPTH      (DEPTH),
      .CNT_WIDTH  (CNT_WIDTH),
      .DROP_PERIOD(DROP_PERIOD)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .rx_tdata     (rx_tdata),
      .rx_tkeep     (rx_tkeep),
      .rx_tvalid    (rx_tvalid),
      .rx_tready    (rx_tready),
      .rx_tlast     (rx_tlast),
      .tx_tdata     (tx_tdata),
      .tx_tkeep     (tx_tkeep),
      .tx_tvalid    (tx_tvalid),
      .tx_tready    (tx_tready),
      .tx_tlast     (tx_tlast),
      .HostLoad     (HostLoad),
      .FramesRx     (FramesRx),
      .FramesTx     (FramesTx),
      .FramesBad    (FramesBad),
      .FramesDropped(FramesDropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_valid, exp_rx, exp_bad, exp_drop;
   logic [32:0] got_q[$];
   logic [32:0] exp_q[$];
   bit          rnd_ready = 1'b0;
   bit          c_done;
   logic [31:0] hold;
   logic [32:0] t1 [7] = '{{1'b0, 32'h1000_0000}, {1'b0, 32'h1000_0001}, {1'b0, 32'h1000_0002},
                            {1'b0, 32'h1000_0003}, {1'b0, 32'h1000_0009}, {1'b0, 32'h1234_000A},
                            {1'b1, 32'h0000_ABCD}};

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Beats are recorded mid-cycle; a valid&ready seen here completes at the next rising edge.
   initial forever begin
      @(negedge clk);
      if (resetn && tx_tvalid && tx_tready) got_q.push_back({tx_tlast, tx_tdata});
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) tx_tready = 1'($urandom_range(0, 1));
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_model();
      n_valid = 0; exp_rx = 0; exp_bad = 0; exp_drop = 0;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clear_model();
      resetn = 1'b1;
   endtask

   task automatic send_frame(input int n, input logic [31:0] base, input bit rnd, input bit model,
                             input int max_gap);
      logic [31:0] w[$];
      logic [31:0] word;
      bit          ok;
      int          b;
      for (int i = 0; i < n; i++) begin
         word = rnd ? $urandom : base + 32'(i);
         w.push_back(word);
         repeat ($urandom_range(0, max_gap)) begin
            rx_tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         rx_tdata  = word;
         rx_tvalid = 1'b1;
         rx_tlast  = (i == n - 1);
         ok = 1'b0;
         b  = 0;
         while (!ok && b < 3000) begin
            @(negedge clk);
            ok = rx_tready;
            @(posedge clk);
            #1;
            b++;
         end
         if (!ok) check_eq("rx_timeout", 64'(ok), 64'd1);
      end
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      if (n < int'(IN_WORDS)) begin
         exp_bad++;
      end else begin
         n_valid++;
         if (DropEn && (n_valid % DROP_PERIOD == 0)) begin
            exp_drop++;
         end else begin
            exp_rx++;
            if (model) begin
               exp_q.push_back({1'b0, w[0]});
               exp_q.push_back({1'b0, w[1]});
               exp_q.push_back({1'b0, w[2]});
               exp_q.push_back({1'b0, w[8][31:16], w[3][15:0]});
               exp_q.push_back({1'b0, w[9]});
               exp_q.push_back({1'b0, HostLoad[15:0], w[10][15:0]});
               exp_q.push_back({1'b1, 16'h0, HostLoad[31:16]});
            end
         end
      end
   endtask

   task automatic drain(input string tag);
      int b = 0;
      while (got_q.size() < exp_q.size() && b < 20000) begin
         @(posedge clk);
         b++;
      end
      repeat (20) @(posedge clk);
      #1;
      check_eq({tag, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0) check_eq(tag, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_counters(input string tag);
      check_eq({tag, "_rx"},   FramesRx,      exp_rx);
      check_eq({tag, "_tx"},   FramesTx,      exp_rx);
      check_eq({tag, "_bad"},  FramesBad,     exp_bad);
      check_eq({tag, "_drop"}, FramesDropped, exp_drop);
   endtask

   initial begin
      resetn = 1'b0; rx_tdata = '0; rx_tkeep = 4'hF; rx_tvalid = 1'b0; rx_tlast = 1'b0;
      tx_tready = 1'b0; HostLoad = 32'hABCD_1234;
      clear_model();
      #12;
      check_eq("rst_rx_tready", rx_tready, 1);
      check_eq("rst_tx_tvalid", tx_tvalid, 0);
      check_eq("rst_tx_tlast",  tx_tlast,  0);
      check_eq("tx_tkeep",      tx_tkeep,  4'hF);
      check_counters("rst");
      @(posedge clk);
      #1;
      resetn    = 1'b1;
      tx_tready = 1'b1;

      // Single frame, latency and hand-computed reduction.
      send_frame(12, 32'h1000_0000, 1'b0, 1'b0, 0);
      check_eq("lat0", tx_tvalid, 0);
      @(posedge clk); #1;
      check_eq("lat1", tx_tvalid, 0);
      @(posedge clk); #1;
      check_eq("lat2", tx_tvalid, 1);
      for (int i = 0; i < 7; i++) exp_q.push_back(t1[i]);
      drain("t1");
      check_counters("t1");

      // Short frame then a good one.
      send_frame(5, 32'h2000_0000, 1'b0, 1'b1, 0);
      repeat (10) @(posedge clk);
      #1;
      check_eq("short_no_tx", 64'(got_q.size()), 64'd0);
      check_eq("short_bad", FramesBad, 1);
      send_frame(12, 32'h3000_0000, 1'b0, 1'b1, 0);
      drain("after_short");

      // Overlong frame.
      send_frame(20, 32'h4000_0000, 1'b0, 1'b1, 0);
      drain("long");
      check_counters("long");

      // Backpressure with three back-to-back frames.
      tx_tready = 1'b0;
      send_frame(12, 32'h5000_0000, 1'b0, 1'b1, 0);
      send_frame(12, 32'h6000_0000, 1'b0, 1'b1, 0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("bp_full", rx_tready, 0);
      check_eq("bp_valid", tx_tvalid, 1);
      check_eq("bp_head", tx_tdata, 32'h5000_0000);
      hold   = tx_tdata;
      c_done = 1'b0;
      fork
         begin
            send_frame(12, 32'h7000_0000, 1'b0, 1'b1, 0);
            c_done = 1'b1;
         end
      join_none
      repeat (10) @(posedge clk);
      #1;
      check_eq("bp_stall_ready", rx_tready, 0);
      check_eq("bp_stable", tx_tdata, hold);
      check_eq("bp_stable_last", tx_tlast, 0);
      check_eq("bp_rx", FramesRx, exp_rx);
      check_eq("bp_c_pending", c_done, 0);
      tx_tready = 1'b1;
      for (int b = 0; b < 500 && !c_done; b++) @(posedge clk);
      check_eq("bp_c_done", c_done, 1);
      drain("bp");
      check_counters("bp");

      // Random gaps and random tx_tready over 100 frames.
      do_reset();
      HostLoad  = 32'h5A5A_C3C3;
      rnd_ready = 1'b1;
      for (int f = 0; f < 100; f++) begin
         send_frame((f % 7 == 3) ? int'($urandom_range(13, 18)) : 12, '0, 1'b1, 1'b1, 2);
      end
      rnd_ready = 1'b0;
      #2;
      tx_tready = 1'b1;
      drain("rnd");
      check_counters("rnd");
      check_eq("rnd_tx_total", FramesTx, DropEn ? 88 : 100);

      // Reset while TX is mid-frame and RX is mid-frame.
      tx_tready = 1'b0;
      send_frame(12, 32'h8000_0000, 1'b0, 1'b1, 0);
      repeat (3) @(posedge clk);
      #1;
      rx_tvalid = 1'b1;
      rx_tlast  = 1'b0;
      rx_tdata  = 32'h9000_0000;
      repeat (4) @(posedge clk);
      #1;
      check_eq("pre_rst_valid", tx_tvalid, 1);
      #2;
      resetn = 1'b0;
      #1;
      check_eq("mid_rst_tvalid", tx_tvalid, 0);
      check_eq("mid_rst_tlast",  tx_tlast,  0);
      check_eq("mid_rst_tready", rx_tready, 1);
      rx_tvalid = 1'b0;
      clear_model();
      check_counters("mid_rst");
      @(posedge clk);
      #1;
      resetn    = 1'b1;
      tx_tready = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check_eq("rst_no_tx", 64'(got_q.size()), 64'd0);
      check_eq("rst_no_rx", FramesRx, 0);
      send_frame(12, 32'hA000_0000, 1'b0, 1'b1, 0);
      drain("post_rst");
      check_counters("post_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
